// File: rtl/fa_bist_checker.sv
// fa_bist_checker: exhaustive built-in self-test for a single full adder.
// Applies all eight {cin,a,b} vectors, holds each one for SETTLE_CYCLES cycles and then
// compares the adder outputs in a one-cycle sample slot. It reports a mismatch count,
// a pass flag and a one-cycle done pulse.
//
// Optional feature macro: FA_BIST_ERRLOG_EN. When defined, the module also captures the
// first failing vector of a run and the {cout,sum} value observed for it.
//
// Ports:
//   clk            clock, rising-edge
//   rst_n          asynchronous active-low reset
//   start_i        run request, only sampled while idle
//   dut_sum_i      sum output of the adder under test
//   dut_cout_i     carry output of the adder under test
//   dut_a_o        stimulus a (registered)
//   dut_b_o        stimulus b (registered)
//   dut_cin_o      stimulus cin (registered)
//   busy_o         high from the cycle after an accepted start through the done cycle
//   done_o         one-cycle pulse at the end of a run
//   pass_o         run result, valid from done until the next accepted start
//   err_count_o    number of mismatching vectors (0..8)
//   fail_valid_o   (FA_BIST_ERRLOG_EN) a mismatch has been captured in this run
//   first_fail_vec_o (FA_BIST_ERRLOG_EN) index of the first failing vector
//   first_fail_obs_o (FA_BIST_ERRLOG_EN) observed {cout,sum} for that vector
module fa_bist_checker #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       dut_sum_i,
   input  logic       dut_cout_i,
   output logic       dut_a_o,
   output logic       dut_b_o,
   output logic       dut_cin_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       pass_o,
   output logic [3:0] err_count_o
`ifdef FA_BIST_ERRLOG_EN
   ,
   output logic       fail_valid_o,
   output logic [2:0] first_fail_vec_o,
   output logic [1:0] first_fail_obs_o
`endif
);

   localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

   state_e     state_q, state_d;
   logic [2:0] vec_q, vec_d;
   logic [3:0] settle_q, settle_d;
   logic [2:0] stim_q, stim_d;    // {cin, a, b} as currently applied to the adder
   logic [3:0] err_q, err_d;
   logic       pass_q, pass_d;
   logic       exp_sum, exp_cout, mismatch;

`ifdef FA_BIST_ERRLOG_EN
   logic       fail_valid_q, fail_valid_d;
   logic [2:0] fail_vec_q, fail_vec_d;
   logic [1:0] fail_obs_q, fail_obs_d;
`endif

   // Golden full-adder response for the vector currently on the stimulus flops.
   always_comb begin
      exp_sum  = stim_q[2] ^ stim_q[1] ^ stim_q[0];
      exp_cout = (stim_q[2] & stim_q[1]) | (stim_q[2] & stim_q[0]) | (stim_q[1] & stim_q[0]);
      mismatch = (dut_sum_i != exp_sum) || (dut_cout_i != exp_cout);
   end

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      settle_d = settle_q;
      err_d    = err_q;
      pass_d   = pass_q;
`ifdef FA_BIST_ERRLOG_EN
      fail_valid_d = fail_valid_q;
      fail_vec_d   = fail_vec_q;
      fail_obs_d   = fail_obs_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d  = StDrive;
               vec_d    = 3'd0;
               settle_d = 4'd0;
               err_d    = 4'd0;
               pass_d   = 1'b0;
`ifdef FA_BIST_ERRLOG_EN
               fail_valid_d = 1'b0;
               fail_vec_d   = 3'd0;
               fail_obs_d   = 2'b00;
`endif
            end
         end
         StDrive: begin
            if (settle_q == SettleLast) begin
               state_d  = StSample;
               settle_d = 4'd0;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         StSample: begin
            if (mismatch) begin
               err_d = err_q + 4'd1;
`ifdef FA_BIST_ERRLOG_EN
               // Only the first mismatch of a run is logged.
               if (!fail_valid_q) begin
                  fail_valid_d = 1'b1;
                  fail_vec_d   = vec_q;
                  fail_obs_d   = {dut_cout_i, dut_sum_i};
               end
`endif
            end
            if (vec_q == 3'd7) begin
               state_d = StDone;
               pass_d  = (err_d == 4'd0);  // includes the vector sampled this cycle
            end else begin
               state_d = StDrive;
               vec_d   = vec_q + 3'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Stimulus follows the vector index while running and parks at zero when idle.
      stim_d = (state_d == StIdle) ? 3'd0 : vec_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         vec_q    <= 3'd0;
         settle_q <= 4'd0;
         stim_q   <= 3'd0;
         err_q    <= 4'd0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         settle_q <= settle_d;
         stim_q   <= stim_d;
         err_q    <= err_d;
         pass_q   <= pass_d;
      end
   end

`ifdef FA_BIST_ERRLOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_valid_q <= 1'b0;
         fail_vec_q   <= 3'd0;
         fail_obs_q   <= 2'b00;
      end else begin
         fail_valid_q <= fail_valid_d;
         fail_vec_q   <= fail_vec_d;
         fail_obs_q   <= fail_obs_d;
      end
   end

   assign fail_valid_o     = fail_valid_q;
   assign first_fail_vec_o = fail_vec_q;
   assign first_fail_obs_o = fail_obs_q;
`endif

   assign dut_cin_o   = stim_q[2];
   assign dut_a_o     = stim_q[1];
   assign dut_b_o     = stim_q[0];
   assign busy_o      = (state_q != StIdle);
   assign done_o      = (state_q == StDone);
   assign pass_o      = pass_q;
   assign err_count_o = err_q;

endmodule

// File: doc/fa_bist_checker.md
FA_BIST_CHECKER -- requirements
Module: fa_bist_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, meaning cycles each vector is driven before DUT outputs are sampled; legal range 1..15.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one exhaustive run; sampled only in IDLE.
REQ-005 dut_sum  input  1  sum output of full adder under test.
REQ-006 dut_cout  input  1  carry output of full adder under test.
REQ-007 dut_a, dut_b, dut_cin  output  1 each  stimulus to full adder under test, registered.
REQ-008 busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
REQ-009 done  output  1  one-cycle pulse at end of run.
REQ-010 pass  output  1  run result; meaningful from the DONE cycle until the next accepted start.
REQ-011 err_count  output  4  number of mismatching vectors in current/last run (0..8).

Function
REQ-012 States: IDLE, DRIVE, SAMPLE, DONE; encoding free.
REQ-013 Vector index v (3 bits) counts 0..7; dut_cin=v[2], dut_a=v[1], dut_b=v[0].
REQ-014 IDLE: dut_a/b/cin=0, busy=0, done=0; on start=1 -> DRIVE with v=0, err_count=0, pass=0.
REQ-015 DRIVE: hold vector for exactly SETTLE_CYCLES cycles, then -> SAMPLE.
REQ-016 SAMPLE (one cycle): expected sum = a^b^cin, expected cout = majority(a,b,cin); any mismatch on either bit increments err_count by 1 (once per vector).
REQ-017 SAMPLE with v<7 -> DRIVE with v+1; with v=7 -> DONE.
REQ-018 DONE (one cycle): done=1, pass=1 iff final err_count==0, busy=1; -> IDLE; dut_a/b/cin return to 0 in IDLE.
REQ-019 Latency: start sampled at edge N -> done high in cycle N+8*(SETTLE_CYCLES+1)+1.
REQ-020 start while busy (DRIVE/SAMPLE/DONE) is ignored; no queuing.
REQ-021 start held high continuously: new run accepted on the first IDLE cycle after DONE (one idle cycle between runs).
REQ-022 err_count and pass hold their values in IDLE until the next accepted start.
REQ-023 err_count width guarantees no overflow (max 8); no saturation logic.

Reset
REQ-024 rst_n low asynchronously forces: state=IDLE, v=0, dut_a/b/cin=0, busy=0, done=0, pass=0, err_count=0, settle counter=0.
REQ-025 Reset mid-run aborts the run; no done pulse is produced for the aborted run.
REQ-026 After rst_n deasserts, first start is accepted on the first rising edge where start=1.

Configuration
REQ-027 Macro FA_BIST_ERRLOG_EN defined: adds outputs fail_valid (1), first_fail_vec (3), first_fail_obs (2, {cout,sum}).
REQ-028 With FA_BIST_ERRLOG_EN: on first mismatch of a run, capture v and observed {dut_cout,dut_sum}, set fail_valid=1; later mismatches do not overwrite; all three cleared on accepted start and on reset.
REQ-029 Without FA_BIST_ERRLOG_EN: those ports and their registers do not exist; all other behaviour identical.

Verification (SETTLE_CYCLES=1 unless stated)
REQ-030 Correct full-adder model, start pulse at edge 0 -> busy next cycle, done pulse at cycle 17, pass=1, err_count=0.
REQ-031 dut_sum stuck at 0 -> err_count=4 (vectors 1,2,4,7), pass=0; with ERRLOG: first_fail_vec=1, first_fail_obs=2'b00, fail_valid=1.
REQ-032 dut_cout inverted -> err_count=8, pass=0; no wrap of err_count.
REQ-033 rst_n pulsed low during vector 3 -> all outputs 0 immediately, no done; fresh start then completes with pass=1.
REQ-034 start held high for 40 cycles -> runs complete at cycles 17 and 35; start pulses during busy cause no extra runs.
REQ-035 SETTLE_CYCLES=3, correct model -> done at cycle 33, each vector held 4 cycles, pass=1.
